// File: rtl/inst_mem_loader.sv
// Serial program loader: receives a framed image over UART 8N1 and writes
// big-endian 32-bit words into instruction memory, holding the CPU while loading.
//
// RX FSM   state   | meaning
//          R_IDLE  | line idle, waiting for a falling edge
//          R_START | timing to mid start bit, reject glitches
//          R_DATA  | sampling 8 data bits LSB first
//          R_STOP  | sampling stop bit, emit byte or framing error
// Frame FSM state  | meaning
//          IDLE    | waiting for 0xA5 header (load_done may be high)
//          CNT_HI  | expecting word-count high byte
//          CNT_LO  | expecting word-count low byte
//          DATA    | assembling words and writing them
//          CKSUM   | expecting XOR checksum of data bytes
//          ERR     | load failed, waiting for a new header
module inst_mem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 10,
    parameter int MAX_WORDS    = 1024
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    HDR    = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CKSUM, ERR} fr_state_t;

    logic            r_rx_meta, r_rx_sync;
    rx_state_t       r_rx_state, w_rx_next;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_rx_shift;
    logic            r_rx_valid, r_rx_ferr;
    logic [7:0]      r_rx_byte;
    logic            w_tc;

    fr_state_t       r_state, w_next;
    logic [7:0]      r_cnt_hi;
    logic [15:0]     r_n;
    logic [15:0]     r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [23:0]     r_asm;
    logic [7:0]      r_cksum;
    logic            r_done;
    logic            r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]     r_wr_data;
    logic [15:0]     w_n;
    logic            w_last_byte, w_last_word;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_tc = (r_timer == '0);

    always_ff @(posedge CLOCK_50) begin
        if (rst) r_rx_state <= R_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (!r_rx_sync) w_rx_next = R_START;
            R_START: if (w_tc) w_rx_next = r_rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (w_tc && r_bit_idx == 3'd7) w_rx_next = R_STOP;
            R_STOP:  if (w_tc) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // Down-counter timer reloads on every sample point.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                R_IDLE: r_timer <= T_HALF;
                R_START: begin
                    if (w_tc) begin
                        r_timer   <= T_FULL;
                        r_bit_idx <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_tc) begin
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        r_timer    <= T_FULL;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                R_STOP: begin
                    if (w_tc) begin
                        if (r_rx_sync) begin
                            r_rx_valid <= 1'b1;
                            r_rx_byte  <= r_rx_shift;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: r_timer <= T_HALF;
            endcase
        end
    end

    assign w_n         = {r_cnt_hi, r_rx_byte};
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = (r_word_idx == r_n - 16'd1);

    always_ff @(posedge CLOCK_50) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, ERR: if (r_rx_valid && r_rx_byte == HDR) w_next = CNT_HI;
            CNT_HI: begin
                if (r_rx_ferr)       w_next = ERR;
                else if (r_rx_valid) w_next = CNT_LO;
            end
            CNT_LO: begin
                if (r_rx_ferr) w_next = ERR;
                else if (r_rx_valid) begin
                    if ({16'd0, w_n} > 32'(MAX_WORDS)) w_next = ERR;
                    else if (w_n == 16'd0)             w_next = CKSUM;
                    else                               w_next = DATA;
                end
            end
            DATA: begin
                if (r_rx_ferr) w_next = ERR;
                else if (r_rx_valid && w_last_byte && w_last_word) w_next = CKSUM;
            end
            CKSUM: begin
                if (r_rx_ferr) w_next = ERR;
                else if (r_rx_valid) w_next = (r_rx_byte == r_cksum) ? IDLE : ERR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_cnt_hi   <= '0;
            r_n        <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_asm      <= '0;
            r_cksum    <= '0;
            r_done     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_rx_valid) begin
                case (r_state)
                    IDLE, ERR: begin
                        if (r_rx_byte == HDR) begin
                            r_done     <= 1'b0;
                            r_cksum    <= '0;
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                    CNT_HI: r_cnt_hi <= r_rx_byte;
                    CNT_LO: begin
                        r_n        <= w_n;
                        r_cksum    <= '0;
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                    end
                    DATA: begin
                        r_asm      <= {r_asm[15:0], r_rx_byte};
                        r_cksum    <= r_cksum ^ r_rx_byte;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_word_idx[ADDR_W-1:0];
                            r_wr_data  <= {r_asm, r_rx_byte};
                            r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                    CKSUM: if (r_rx_byte == r_cksum) r_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cpu_hold  = 1'b0;
        load_err  = 1'b0;
        load_done = r_done;
        case (r_state)
            CNT_HI, CNT_LO, DATA, CKSUM: cpu_hold = 1'b1;
            ERR:                         load_err = 1'b1;
            default: ;
        endcase
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
